// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: takes fetch addresses from the PC stage, issues reads to a synchronous
// instruction ROM with fixed latency and buffers the returned words in an in-order FIFO.
// Decode takes the words from that FIFO over a valid/ready handshake.
// Ports:
//   clk, reset         single clock; asynchronous active-high reset
//   req_valid/req_pc   fetch address offered by the PC stage; req_ready accepts it
//   flush              branch redirect, drops every in-flight and buffered fetch
//   rom_en/rom_addr    ROM read strobe and word-aligned address (combinational on accept)
//   rom_data           ROM read data, valid ROM_LATENCY cycles after rom_en
//   out_valid/ready    decode handshake; out_pc/out_instr/out_misalign describe the FIFO head
module instr_fetch_queue #(
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  input  logic              flush,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              out_misalign
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // In-flight shift register: stage 0 is loaded on accept, the last stage lines up with rom_data.
  logic [ROM_LATENCY-1:0] infl_vld_q;
  logic [ROM_LATENCY-1:0] infl_mis_q;
  logic [ADDR_W-1:0]      infl_pc_q [ROM_LATENCY];
  logic [CntW-1:0]        infl_cnt_q;

  // FIFO storage and pointers.
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]  mis_mem;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;

  logic [CntW:0] occupancy;
  logic          accept;
  logic          tail_vld;
  logic          push;
  logic          pop;

  // Credit check counts in-flight reads, so every returning word has a free FIFO slot.
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, infl_cnt_q};
  assign req_ready = !reset && !flush && (occupancy < (CntW + 1)'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign rom_en    = accept;
  assign rom_addr  = {req_pc[ADDR_W-1:2], 2'b00};

  assign tail_vld  = infl_vld_q[ROM_LATENCY-1];
  assign push      = tail_vld && !flush;
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready && !flush;

  assign out_pc       = pc_mem[rd_ptr_q];
  assign out_instr    = instr_mem[rd_ptr_q];
  assign out_misalign = mis_mem[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      infl_vld_q <= '0;
      infl_mis_q <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        infl_pc_q[i] <= '0;
      end
    end else begin
      // accept is already low during flush, so stage 0 clears itself.
      infl_vld_q[0] <= accept;
      infl_pc_q[0]  <= req_pc;
      infl_mis_q[0] <= |req_pc[1:0];
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        infl_vld_q[i] <= infl_vld_q[i-1] && !flush;
        infl_pc_q[i]  <= infl_pc_q[i-1];
        infl_mis_q[i] <= infl_mis_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      infl_cnt_q <= '0;
    end else if (flush) begin
      infl_cnt_q <= '0;
    end else if (accept && !tail_vld) begin
      infl_cnt_q <= infl_cnt_q + 1'b1;
    end else if (!accept && tail_vld) begin
      infl_cnt_q <= infl_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      mis_mem    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr_q]    <= infl_pc_q[ROM_LATENCY-1];
        instr_mem[wr_ptr_q] <= rom_data;
        mis_mem[wr_ptr_q]   <= infl_mis_q[ROM_LATENCY-1];
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] XorKey = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .ROM_LATENCY(L),
    .DEPTH      (DEPTH),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .flush       (flush),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_misalign(out_misalign)
  );

  // ROM: data = addr ^ key, delayed L cycles.
  logic [31:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr ^ XorKey;
    for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[L-1];

  // Reference model: a list of outstanding reads with their return cycle, and a list of
  // buffered instructions in request order.
  typedef struct {logic [31:0] pc; int due;} infl_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic mis;} ent_t;
  infl_t m_infl[$];
  ent_t  m_fifo[$];
  int    cyc = 0;

  function automatic logic m_ready();
    return !reset && !flush && ((m_fifo.size() + m_infl.size()) < DEPTH);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_infl.delete();
        m_fifo.delete();
        cyc = 0;
      end else begin
        logic acc;
        acc = req_valid && m_ready();
        if (flush) begin
          m_infl.delete();
          m_fifo.delete();
        end else begin
          if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
          if (m_infl.size() != 0 && m_infl[0].due == cyc) begin
            ent_t e;
            e.pc    = m_infl[0].pc;
            e.instr = {m_infl[0].pc[31:2], 2'b00} ^ XorKey;
            e.mis   = (m_infl[0].pc[1:0] != 2'b00);
            m_fifo.push_back(e);
            void'(m_infl.pop_front());
          end
          if (acc) begin
            infl_t f;
            f.pc  = req_pc;
            f.due = cyc + L;
            m_infl.push_back(f);
          end
        end
        cyc++;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (rom_en !== 1'b0) $display("FAIL rst_rom_en got %b want 0", rom_en); else n_pass++;
    n_checks++; if (out_pc !== 32'h0) $display("FAIL rst_out_pc got %h want 0", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr got %h want 0", out_instr); else n_pass++;
    n_checks++; if (out_misalign !== 1'b0) $display("FAIL rst_misalign got %b want 0", out_misalign); else n_pass++;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b1; req_pc = 32'h80; out_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else n_pass++;
    @(negedge clk); req_pc = 32'h84;
    @(negedge clk); req_pc = 32'h88;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_pc = 32'h90;
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_fill_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (rom_en !== 1'b1) $display("FAIL rst_fill_rom_en got %b want 1", rom_en); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (rom_en !== 1'b0) $display("FAIL rst_async_rom_en got %b want 0", rom_en); else n_pass++;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_release_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic        exp_v;
    logic [31:0] exp_pc;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req_valid = (k < 4); req_pc = 32'(4 * k); out_ready = 1'b1; flush = 1'b0;
      #1;
      exp_v = (k >= L + 1) && (k <= L + 4);
      n_checks++; if (out_valid !== exp_v) $display("FAIL b2b_valid k=%0d got %b want %b", k, out_valid, exp_v); else n_pass++;
      n_checks++; if (rom_en !== (k < 4)) $display("FAIL b2b_rom_en k=%0d got %b want %b", k, rom_en, (k < 4)); else n_pass++;
      if (exp_v) begin
        exp_pc = 32'(4 * (k - L - 1));
        n_checks++; if (out_pc !== exp_pc) $display("FAIL b2b_pc k=%0d got %h want %h", k, out_pc, exp_pc); else n_pass++;
        n_checks++; if (out_instr !== (exp_pc ^ XorKey)) $display("FAIL b2b_instr k=%0d got %h want %h", k, out_instr, exp_pc ^ XorKey); else n_pass++;
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure;
    int acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h20 + 32'(4 * acc);
      #1;
      if (req_ready) acc++;
    end
    n_checks++; if (acc !== 4) $display("FAIL bp_accepted got %0d want 4", acc); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", req_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_pop_valid i=%0d got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (out_pc !== 32'h20 + 32'(4 * i)) $display("FAIL bp_pop_pc i=%0d got %h want %h", i, out_pc, 32'h20 + 32'(4 * i)); else n_pass++;
      n_checks++; if (req_ready !== (i != 0)) $display("FAIL bp_ready i=%0d got %b want %b", i, req_ready, (i != 0)); else n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", out_valid); else n_pass++;
    idle(1);
  endtask

  task automatic test_flush;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h40 + 32'(4 * k);
      #1;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL fl_issue k=%0d got %b want 1", k, req_ready); else n_pass++;
    end
    // Two words buffered, two still in flight.
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL fl_ready got %b want 0", req_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL fl_pre_valid got %b want 1", out_valid); else n_pass++;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b1; req_pc = 32'h100;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fl_post_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL fl_post_ready got %b want 1", req_ready); else n_pass++;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== (k == L + 1)) $display("FAIL fl_new_valid k=%0d got %b want %b", k, out_valid, (k == L + 1)); else n_pass++;
    end
    n_checks++; if (out_pc !== 32'h100) $display("FAIL fl_new_pc got %h want 100", out_pc); else n_pass++;
    n_checks++; if (out_instr !== (32'h100 ^ XorKey)) $display("FAIL fl_new_instr got %h want %h", out_instr, 32'h100 ^ XorKey); else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fl_no_late got %b want 0", out_valid); else n_pass++;
    idle(2);
  endtask

  task automatic test_misalign;
    @(negedge clk);
    req_valid = 1'b1; req_pc = 32'h6; out_ready = 1'b0;
    #1;
    n_checks++; if (rom_en !== 1'b1) $display("FAIL mis_rom_en got %b want 1", rom_en); else n_pass++;
    n_checks++; if (rom_addr !== 32'h4) $display("FAIL mis_rom_addr got %h want 4", rom_addr); else n_pass++;
    repeat (L + 1) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mis_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 32'h6) $display("FAIL mis_pc got %h want 6", out_pc); else n_pass++;
    n_checks++; if (out_misalign !== 1'b1) $display("FAIL mis_flag got %b want 1", out_misalign); else n_pass++;
    n_checks++; if (out_instr !== 32'hA5A5_0004) $display("FAIL mis_instr got %h want a5a50004", out_instr); else n_pass++;
    idle(3);
  endtask

  task automatic test_random;
    logic er;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      req_pc    = $urandom() & 32'h0000_0FFF;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      er = m_ready();
      n_checks++; if (req_ready !== er) $display("FAIL rnd_ready k=%0d got %b want %b", k, req_ready, er); else n_pass++;
      n_checks++; if (rom_en !== (req_valid && er)) $display("FAIL rnd_rom_en k=%0d got %b want %b", k, rom_en, req_valid && er); else n_pass++;
      if (req_valid && er) begin
        n_checks++; if (rom_addr !== {req_pc[31:2], 2'b00}) $display("FAIL rnd_rom_addr k=%0d got %h want %h", k, rom_addr, {req_pc[31:2], 2'b00}); else n_pass++;
      end
      n_checks++; if (out_valid !== (m_fifo.size() != 0)) $display("FAIL rnd_valid k=%0d got %b want %b", k, out_valid, m_fifo.size() != 0); else n_pass++;
      if (m_fifo.size() != 0) begin
        n_checks++; if (out_pc !== m_fifo[0].pc) $display("FAIL rnd_pc k=%0d got %h want %h", k, out_pc, m_fifo[0].pc); else n_pass++;
        n_checks++; if (out_instr !== m_fifo[0].instr) $display("FAIL rnd_instr k=%0d got %h want %h", k, out_instr, m_fifo[0].instr); else n_pass++;
        n_checks++; if (out_misalign !== m_fifo[0].mis) $display("FAIL rnd_mis k=%0d got %b want %b", k, out_misalign, m_fifo[0].mis); else n_pass++;
      end
    end
    idle(10);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rnd_drained got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
